// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, class and opcode definitions for the processor controller
package ctrl_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    S1    = 2'd1,
    S2    = 2'd2,
    S3    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ALU  = 2'b00,
    RSV  = 2'b01,
    ADDI = 2'b10,
    SUBI = 2'b11
  } cls_t;

  localparam logic [3:0] OP_LD  = 4'b0000;
  localparam logic [3:0] OP_CP  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_NOT = 4'b0111;
  localparam logic [3:0] OP_LSL = 4'b1000;
  localparam logic [3:0] OP_LSR = 4'b1001;
  localparam logic [3:0] OP_ROL = 4'b1010;
  localparam logic [3:0] OP_ASR = 4'b1011;

  localparam logic [3:0] ALU_ADD = OP_ADD;
  localparam logic [3:0] ALU_SUB = OP_SUB;

endpackage

// File: rtl/ctrl_decode.sv
// rtl/ctrl_decode.sv - combinational field extraction from the instruction register
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int REG_AW = 2
) (
  input  logic [DATA_W-1:0] i_ir,
  output cls_t              o_cls,
  output logic [REG_AW-1:0] o_rx,
  output logic [REG_AW-1:0] o_ry,
  output logic [3:0]        o_op,
  output logic [DATA_W-1:0] o_imm,
  output logic              o_is_ld,
  output logic              o_is_cp
);

  // Field slicing: class on top, then rx, ry; op and immediate overlap the low bits.
  always_comb begin
    o_cls   = cls_t'(i_ir[DATA_W-1:DATA_W-2]);
    o_rx    = i_ir[DATA_W-3 -: REG_AW];
    o_ry    = i_ir[DATA_W-3-REG_AW -: REG_AW];
    o_op    = i_ir[3:0];
    o_imm   = {{(REG_AW+2){1'b0}}, i_ir[DATA_W-3-REG_AW:0]};
    o_is_ld = (o_cls == ALU) && (o_op == OP_LD);
    o_is_cp = (o_cls == ALU) && (o_op == OP_CP);
  end

endmodule

// File: rtl/controller_fsm.sv
// rtl/controller_fsm.sv - timestep FSM driving all datapath strobes; optional CTRL_ILLEGAL_TRAP_EN traps opcodes
module controller_fsm
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int NREG   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        ext_data,
  input  logic                     ext_valid,
  output logic                     ext_ready,
  output logic [DATA_W-1:0]        IMM,
  output logic                     IMMout,
  output logic [$clog2(NREG)-1:0]  Rin,
  output logic [$clog2(NREG)-1:0]  Rout,
  output logic                     ENW,
  output logic                     ENR,
  output logic                     Ain,
  output logic                     Gin,
  output logic                     Gout,
  output logic [3:0]               ALUcont,
  output logic                     Ext,
  output logic                     IRin,
  output logic [1:0]               T,
  output logic                     done,
  output logic                     illegal
);

  localparam int REG_AW = $clog2(NREG);

  state_t              r_state;
  state_t              w_next;
  logic [DATA_W-1:0]   r_ir;
  cls_t                w_cls;
  logic [REG_AW-1:0]   w_rx;
  logic [REG_AW-1:0]   w_ry;
  logic [3:0]          w_op;
  logic [DATA_W-1:0]   w_imm;
  logic                w_is_ld;
  logic                w_is_cp;
  logic                w_trap;

  ctrl_decode #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_decode (
    .i_ir    (r_ir),
    .o_cls   (w_cls),
    .o_rx    (w_rx),
    .o_ry    (w_ry),
    .o_op    (w_op),
    .o_imm   (w_imm),
    .o_is_ld (w_is_ld),
    .o_is_cp (w_is_cp)
  );

  // Opcodes 1100..1111 and the reserved class trap only when the feature is built in.
  always_comb begin
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_trap = ((w_cls == ALU) && (w_op[3:2] == 2'b11)) || (w_cls == RSV);
`else
    w_trap = 1'b0;
`endif
  end

  // State and instruction register; IR only loads on an accepted fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == FETCH) && ext_valid) begin
        r_ir <= ext_data;
      end
    end
  end

  // Next state and strobe decode; at most one bus driver is ever enabled per state.
  always_comb begin
    w_next    = r_state;
    ext_ready = 1'b0;
    IMM       = '0;
    IMMout    = 1'b0;
    Rin       = '0;
    Rout      = '0;
    ENW       = 1'b0;
    ENR       = 1'b0;
    Ain       = 1'b0;
    Gin       = 1'b0;
    Gout      = 1'b0;
    ALUcont   = 4'b0000;
    Ext       = 1'b0;
    IRin      = 1'b0;
    T         = r_state;
    done      = 1'b0;
    illegal   = 1'b0;
    case (r_state)
      FETCH: begin
        ext_ready = 1'b1;
        Ext       = ext_valid;
        IRin      = ext_valid;
        if (ext_valid) w_next = S1;
      end
      S1: begin
        if (w_trap) begin
          illegal = 1'b1;
          w_next  = FETCH;
        end else if (w_cls == RSV) begin
          done   = 1'b1;
          w_next = FETCH;
        end else if (w_is_ld) begin
          // Load stalls here until the external source offers a word.
          ext_ready = 1'b1;
          Ext       = ext_valid;
          ENR       = ext_valid;
          Rin       = w_rx;
          done      = ext_valid;
          if (ext_valid) w_next = FETCH;
        end else if (w_is_cp) begin
          Rout   = w_ry;
          ENW    = 1'b1;
          Rin    = w_rx;
          ENR    = 1'b1;
          done   = 1'b1;
          w_next = FETCH;
        end else begin
          Rout   = w_rx;
          ENW    = 1'b1;
          Ain    = 1'b1;
          w_next = S2;
        end
      end
      S2: begin
        Gin    = 1'b1;
        w_next = S3;
        case (w_cls)
          ALU: begin
            Rout    = w_ry;
            ENW     = 1'b1;
            ALUcont = w_op;
          end
          ADDI: begin
            IMMout  = 1'b1;
            IMM     = w_imm;
            ALUcont = ALU_ADD;
          end
          SUBI: begin
            IMMout  = 1'b1;
            IMM     = w_imm;
            ALUcont = ALU_SUB;
          end
          default: ;
        endcase
      end
      S3: begin
        Gout   = 1'b1;
        Rin    = w_rx;
        ENR    = 1'b1;
        done   = 1'b1;
        w_next = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end

endmodule

// File: tb/tb_controller_fsm.sv
// tb/tb_controller_fsm.sv - randomized self-checking bench for controller_fsm (honours CTRL_ILLEGAL_TRAP_EN)
module tb_controller_fsm;

  typedef struct packed {
    logic       ext_ready;
    logic [9:0] imm;
    logic       immout;
    logic [1:0] rin;
    logic [1:0] rout;
    logic       enw;
    logic       enr;
    logic       ain;
    logic       gin;
    logic       gout;
    logic [3:0] alu;
    logic       ext;
    logic       irin;
    logic [1:0] t;
    logic       done;
    logic       illegal;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] ext_data = '0;
  logic       ext_valid = 1'b0;
  logic       ext_ready;
  logic [9:0] IMM;
  logic       IMMout;
  logic [1:0] Rin;
  logic [1:0] Rout;
  logic       ENW, ENR, Ain, Gin, Gout, Ext, IRin, done, illegal;
  logic [3:0] ALUcont;
  logic [1:0] T;
  outs_t      obs;

  int n_checks = 0;
  int n_errors = 0;

  controller_fsm #(.DATA_W(10), .NREG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ext_data  (ext_data),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .IMM       (IMM),
    .IMMout    (IMMout),
    .Rin       (Rin),
    .Rout      (Rout),
    .ENW       (ENW),
    .ENR       (ENR),
    .Ain       (Ain),
    .Gin       (Gin),
    .Gout      (Gout),
    .ALUcont   (ALUcont),
    .Ext       (Ext),
    .IRin      (IRin),
    .T         (T),
    .done      (done),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  assign obs = {ext_ready, IMM, IMMout, Rin, Rout, ENW, ENR, Ain, Gin, Gout,
                ALUcont, Ext, IRin, T, done, illegal};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic outs_t base(input logic [1:0] t);
    outs_t e;
    e   = '0;
    e.t = t;
    return e;
  endfunction

  function automatic outs_t idle();
    outs_t e;
    e           = base(2'd0);
    e.ext_ready = 1'b1;
    return e;
  endfunction

  // One clock: drive inputs, compare outputs mid-cycle, advance past the edge.
  task automatic cyc(input logic v, input logic [9:0] d, input outs_t e, input string tag);
    ext_valid = v;
    ext_data  = d;
    @(negedge clk);
    check(tag, 64'(obs), 64'(e));
    check({tag, " bus"}, 64'(int'(ENW) + int'(Gout) + int'(Ext) + int'(IMMout) > 1), 64'(0));
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_trapped(input logic [9:0] w);
`ifdef CTRL_ILLEGAL_TRAP_EN
    return ((w[9:8] == 2'b00) && (w[3:2] == 2'b11)) || (w[9:8] == 2'b01);
`else
    return 1'b0;
`endif
  endfunction

  // Expected cycle sequence for one instruction, written from the instruction-set rules.
  task automatic run_instr(input logic [9:0] w, input int gap, input int stall,
                           input int first_phases, input string tag);
    logic [1:0] cls, rx, ry;
    logic [3:0] op;
    outs_t      e;
    int         ph;
    cls = w[9:8];
    rx  = w[7:6];
    ry  = w[5:4];
    op  = w[3:0];
    for (int i = 0; i < gap; i++) cyc(1'b0, 10'($urandom), idle(), {tag, " wait"});
    e      = idle();
    e.ext  = 1'b1;
    e.irin = 1'b1;
    cyc(1'b1, w, e, {tag, " fetch"});
    ph = 0;
    if (is_trapped(w)) begin
      e         = base(2'd1);
      e.illegal = 1'b1;
      cyc(1'($urandom), 10'($urandom), e, {tag, " trap"});
    end else if (cls == 2'b01) begin
      e      = base(2'd1);
      e.done = 1'b1;
      cyc(1'($urandom), 10'($urandom), e, {tag, " nop"});
    end else if (cls == 2'b00 && op == 4'd0) begin
      for (int i = 0; i < stall; i++) begin
        e           = base(2'd1);
        e.ext_ready = 1'b1;
        e.rin       = rx;
        cyc(1'b0, 10'($urandom), e, {tag, " ld stall"});
      end
      e           = base(2'd1);
      e.ext_ready = 1'b1;
      e.rin       = rx;
      e.ext       = 1'b1;
      e.enr       = 1'b1;
      e.done      = 1'b1;
      cyc(1'b1, 10'($urandom), e, {tag, " ld xfer"});
    end else if (cls == 2'b00 && op == 4'd1) begin
      e      = base(2'd1);
      e.rout = ry;
      e.enw  = 1'b1;
      e.rin  = rx;
      e.enr  = 1'b1;
      e.done = 1'b1;
      cyc(1'($urandom), 10'($urandom), e, {tag, " cp"});
    end else begin
      e      = base(2'd1);
      e.rout = rx;
      e.enw  = 1'b1;
      e.ain  = 1'b1;
      cyc(1'($urandom), 10'($urandom), e, {tag, " t1"});
      ph = 1;
      if (ph < first_phases) begin
        e     = base(2'd2);
        e.gin = 1'b1;
        if (cls == 2'b00) begin
          e.rout = ry;
          e.enw  = 1'b1;
          e.alu  = op;
        end else begin
          e.immout = 1'b1;
          e.imm    = {4'd0, w[5:0]};
          e.alu    = (cls == 2'b10) ? 4'b0010 : 4'b0011;
        end
        cyc(1'($urandom), 10'($urandom), e, {tag, " t2"});
        e      = base(2'd3);
        e.gout = 1'b1;
        e.rin  = rx;
        e.enr  = 1'b1;
        e.done = 1'b1;
        cyc(1'($urandom), 10'($urandom), e, {tag, " t3"});
      end
    end
  endtask

  initial begin
    outs_t      e;
    logic [9:0] w;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(1'b0, 10'h3ff, idle(), "reset");

    run_instr(10'b00_01_10_0010, 0, 0, 9, "add r1,r2");
    run_instr(10'b10_11_000101, 1, 0, 9, "addi r3,5");
    run_instr(10'b11_10_111111, 0, 0, 9, "subi r2,63");
    run_instr(10'b00_10_000000, 0, 3, 9, "ld r2");
    run_instr(10'b00_00_11_0001, 0, 0, 9, "cp r0,r3");
    run_instr(10'b00_01_00_1110, 0, 0, 9, "op 1110");
    run_instr(10'b01_10_010101, 0, 0, 9, "rsv");

    // Abort in S2: the S2 cycle still shows its strobes, then reset forces FETCH with no writeback.
    run_instr(10'b00_11_01_0100, 0, 0, 1, "abort");
    rst   = 1'b1;
    e     = base(2'd2);
    e.gin = 1'b1;
    e.rout = 2'd1;
    e.enw = 1'b1;
    e.alu = 4'b0100;
    cyc(1'b0, 10'h000, e, "abort s2");
    cyc(1'b0, 10'h000, idle(), "abort rst");
    rst = 1'b0;
    cyc(1'b0, 10'h000, idle(), "abort idle");

    for (int n = 0; n < 150; n++) begin
      w = 10'($urandom);
      if ($urandom_range(0, 3) == 0) w[9:8] = 2'b00;
      if ($urandom_range(0, 5) == 0) w[3:1] = 3'b000;
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 3), 9, $sformatf("rnd%0d w=%h", n, w));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
